// File: rtl/acq_readout_sequencer.sv
// Read-side sequencer: arms capture, waits for stored data, then drains the
// storage byte stream into the UART under a valid/ready handshake.
module acq_readout_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter logic [3:0]  SETTLE_CYCLES  = 4'd5,
    parameter logic [15:0] MAX_BYTES      = 16'd4100
) (
    input  logic        ReadClock,
    input  logic        Reset,
    input  logic        ArmCmd,
    input  logic        AbortCmd,
    input  logic        DataReady,
    input  logic [7:0]  DataByte,
    input  logic        TxReady,
    output logic        TriggerEnable,
    output logic        ReadEnable,
    output logic [7:0]  TxData,
    output logic        TxValid,
    output logic        Busy,
    output logic        DonePulse,
    output logic        TimeoutFlag,
    output logic        OverrunFlag,
    output logic [15:0] ByteCount,
    output logic [2:0]  DbgState
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_PRESENT = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Handshake: a byte transfers on any cycle where TxValid and TxReady are
    // both high; TxValid/TxData hold stable until that cycle.

    state_t      r_state;
    logic [23:0] r_timeout;
    logic [3:0]  r_settle;
    logic        r_trigger_en;
    logic        r_read_en;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_done;
    logic        r_timeout_flag;
    logic        r_overrun;
    logic [15:0] r_byte_count;

    logic        w_accept;
    logic [15:0] w_count_inc;
    logic [3:0]  w_settle_load;

    assign w_accept      = r_tx_valid & TxReady;
    assign w_count_inc   = (r_byte_count == 16'hFFFF) ? r_byte_count : r_byte_count + 16'd1;
    assign w_settle_load = SETTLE_CYCLES - 4'd1;

    always_ff @(posedge ReadClock) begin
        if (Reset) begin
            r_state        <= ST_IDLE;
            r_timeout      <= 24'd0;
            r_settle       <= 4'd0;
            r_trigger_en   <= 1'b0;
            r_read_en      <= 1'b0;
            r_tx_data      <= 8'd0;
            r_tx_valid     <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_overrun      <= 1'b0;
            r_byte_count   <= 16'd0;
        end else begin
            r_read_en <= 1'b0;
            r_done    <= 1'b0;
            if ((r_state != ST_IDLE) && AbortCmd) begin
                // A byte the UART takes on the abort cycle is still counted.
                r_state      <= ST_IDLE;
                r_trigger_en <= 1'b0;
                r_tx_valid   <= 1'b0;
                if (w_accept) begin
                    r_byte_count <= w_count_inc;
                    if (w_count_inc > MAX_BYTES) begin
                        r_overrun <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ArmCmd) begin
                            r_timeout_flag <= 1'b0;
                            r_overrun      <= 1'b0;
                            r_byte_count   <= 16'd0;
                            r_timeout      <= TIMEOUT_CYCLES;
                            r_trigger_en   <= 1'b1;
                            r_state        <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        // DataReady is checked first so it wins over expiry.
                        if (DataReady) begin
                            r_trigger_en <= 1'b0;
                            r_settle     <= w_settle_load;
                            r_state      <= ST_SETTLE;
                        end else if (r_timeout <= 24'd1) begin
                            r_trigger_en   <= 1'b0;
                            r_timeout_flag <= 1'b1;
                            r_timeout      <= 24'd0;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_timeout <= r_timeout - 24'd1;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_settle != 4'd0) begin
                            r_settle <= r_settle - 4'd1;
                        end else if (DataReady) begin
                            r_tx_data  <= DataByte;
                            r_tx_valid <= 1'b1;
                            r_state    <= ST_PRESENT;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_PRESENT: begin
                        if (w_accept) begin
                            r_tx_valid   <= 1'b0;
                            r_byte_count <= w_count_inc;
                            if (w_count_inc > MAX_BYTES) begin
                                r_overrun <= 1'b1;
                                r_state   <= ST_IDLE;
                            end else begin
                                r_read_en <= 1'b1;
                                r_state   <= ST_ADVANCE;
                            end
                        end
                    end
                    ST_ADVANCE: begin
                        r_settle <= w_settle_load;
                        r_state  <= ST_SETTLE;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign TriggerEnable = r_trigger_en;
    assign ReadEnable    = r_read_en;
    assign TxData        = r_tx_data;
    assign TxValid       = r_tx_valid;
    assign Busy          = (r_state != ST_IDLE);
    assign DonePulse     = r_done;
    assign TimeoutFlag   = r_timeout_flag;
    assign OverrunFlag   = r_overrun;
    assign ByteCount     = r_byte_count;
    assign DbgState      = r_state;

endmodule

// File: tb/tb_acq_readout_sequencer.sv
// Bench for acq_readout_sequencer: a storage-block and UART responder drives
// the inputs; each task checks results against stream-level expectations.
module tb_acq_readout_sequencer;

    localparam int TMO  = 100;
    localparam int MAXB = 22;

    logic        ReadClock = 1'b0;
    logic        Reset     = 1'b1;
    logic        ArmCmd    = 1'b0;
    logic        AbortCmd  = 1'b0;
    logic        DataReady = 1'b0;
    logic [7:0]  DataByte  = 8'd0;
    logic        TxReady   = 1'b0;
    logic        TriggerEnable, ReadEnable, TxValid, Busy, DonePulse;
    logic        TimeoutFlag, OverrunFlag;
    logic [7:0]  TxData;
    logic [15:0] ByteCount;
    logic [2:0]  DbgState;

    int checks = 0;
    int errors = 0;

    int         tx_mode   = 0;
    bit         cap_ready = 1'b0;
    int         idx       = 0;
    int         dip       = 0;
    logic [7:0] stream [0:63];
    bit         dip_at [0:63];
    int         stream_len = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         re_count, done_count, te_count, done_at;
    bit         prev_accept = 1'b0;
    bit         prev_hold   = 1'b0;
    bit         prev_abort  = 1'b0;
    logic [7:0] prev_data   = 8'd0;

    acq_readout_sequencer #(
        .TIMEOUT_CYCLES(24'd100),
        .SETTLE_CYCLES (4'd5),
        .MAX_BYTES     (16'd22)
    ) dut (
        .ReadClock    (ReadClock),
        .Reset        (Reset),
        .ArmCmd       (ArmCmd),
        .AbortCmd     (AbortCmd),
        .DataReady    (DataReady),
        .DataByte     (DataByte),
        .TxReady      (TxReady),
        .TriggerEnable(TriggerEnable),
        .ReadEnable   (ReadEnable),
        .TxData       (TxData),
        .TxValid      (TxValid),
        .Busy         (Busy),
        .DonePulse    (DonePulse),
        .TimeoutFlag  (TimeoutFlag),
        .OverrunFlag  (OverrunFlag),
        .ByteCount    (ByteCount),
        .DbgState     (DbgState)
    );

    always #5 ReadClock = ~ReadClock;

    // Responder on the falling edge: UART ready policy, monitor, storage block.
    always @(negedge ReadClock) begin
        if (tx_mode == 0)      TxReady = 1'b1;
        else if (tx_mode == 1) TxReady = ($urandom_range(0, 2) == 0);
        else                   TxReady = 1'b0;

        if (prev_hold && !prev_abort) begin
            checks++;
            if (!TxValid || TxData !== prev_data) begin
                errors++;
                $display("FAIL tx_hold: TxValid=%0b TxData=%02h, required 1/%02h", TxValid, TxData, prev_data);
            end
        end
        if (ReadEnable) begin
            re_count++;
            checks++;
            if (!prev_accept) begin
                errors++;
                $display("FAIL re_order: ReadEnable=1 without a preceding acceptance");
            end
        end
        if (DonePulse) begin
            done_count++;
            done_at = got_q.size();
        end
        if (TriggerEnable) te_count++;

        prev_hold   = TxValid && !TxReady;
        prev_data   = TxData;
        prev_abort  = AbortCmd || Reset;
        prev_accept = TxValid && TxReady;
        if (prev_accept) got_q.push_back(TxData);

        if (Reset) begin
            idx = 0;
            dip = 0;
        end else if (ReadEnable) begin
            idx++;
            dip = (idx < stream_len && dip_at[idx]) ? 2 : 0;
        end else if (dip > 0) begin
            dip--;
        end
        DataReady = cap_ready && !Reset && (idx < stream_len) && (dip == 0);
        DataByte  = (idx < stream_len) ? stream[idx] : 8'h00;
    end

    task automatic tick();
        @(posedge ReadClock);
        #1;
    endtask

    task automatic clear_counts();
        re_count   = 0;
        done_count = 0;
        te_count   = 0;
        done_at    = -1;
        got_q.delete();
    endtask

    task automatic reset_dut();
        Reset     = 1'b1;
        cap_ready = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic arm();
        ArmCmd = 1'b1;
        tick();
        ArmCmd = 1'b0;
    endtask

    // Each group: header 80 02 then 8 data bytes; end marker 80 01.
    // Storage drops DataReady for 2 cycles at every group/marker boundary.
    task automatic build_stream(input int groups);
        stream_len = 0;
        exp_q.delete();
        for (int i = 0; i < 64; i++) dip_at[i] = 1'b0;
        for (int g = 0; g < groups; g++) begin
            dip_at[stream_len] = (g > 0);
            stream[stream_len]     = 8'h80;
            stream[stream_len + 1] = 8'h02;
            stream_len += 2;
            dip_at[stream_len] = 1'b1;
            for (int b = 0; b < 8; b++) begin
                stream[stream_len] = 8'($urandom_range(0, 255));
                stream_len++;
            end
        end
        dip_at[stream_len]     = 1'b1;
        stream[stream_len]     = 8'h80;
        stream[stream_len + 1] = 8'h01;
        stream_len += 2;
        for (int i = 0; i < stream_len; i++) exp_q.push_back(stream[i]);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (Busy && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (Busy) begin
            errors++;
            $display("FAIL %s_idle_wait: Busy=1 after %0d cycles, required 0", name, budget);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        checks++;
        if ({TriggerEnable, ReadEnable, TxData, TxValid, Busy, DonePulse, TimeoutFlag, OverrunFlag, ByteCount} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {TriggerEnable, ReadEnable, TxData, TxValid, Busy, DonePulse, TimeoutFlag, OverrunFlag, ByteCount});
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        tx_mode = 0;
        clear_counts();
        arm();
        repeat (50) tick();
        arm();
        wait_idle(300, "timeout");
        tick();
        checks++;
        if (te_count != TMO) begin
            errors++;
            $display("FAIL timeout_te_cycles: got %0d, required %0d", te_count, TMO);
        end
        checks++;
        if (TimeoutFlag !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got %0b, required 1", TimeoutFlag);
        end
        checks++;
        if (re_count != 0 || done_count != 0) begin
            errors++;
            $display("FAIL timeout_pulses: re=%0d done=%0d, required 0/0", re_count, done_count);
        end
    endtask

    task automatic test_ready_at_expiry();
        reset_dut();
        build_stream(1);
        tx_mode = 0;
        clear_counts();
        arm();
        repeat (TMO - 1) tick();
        cap_ready = 1'b1;
        tick();
        checks++;
        if (Busy !== 1'b1 || TimeoutFlag !== 1'b0 || TriggerEnable !== 1'b0) begin
            errors++;
            $display("FAIL expiry_race: Busy=%0b Timeout=%0b TE=%0b, required 1/0/0", Busy, TimeoutFlag, TriggerEnable);
        end
        wait_idle(1000, "expiry");
        tick();
        checks++;
        if (done_count != 1 || ByteCount !== 16'(stream_len)) begin
            errors++;
            $display("FAIL expiry_readout: done=%0d count=%0d, required 1/%0d", done_count, ByteCount, stream_len);
        end
    endtask

    task automatic run_stream(input int mode, input int groups, input string name);
        int exp_acc, exp_re, exp_done;
        bit exp_over;
        reset_dut();
        build_stream(groups);
        tx_mode = mode;
        clear_counts();
        arm();
        repeat ($urandom_range(3, 30)) tick();
        cap_ready = 1'b1;
        wait_idle(4000, name);
        tick();
        tick();
        exp_over = (stream_len > MAXB);
        exp_acc  = exp_over ? MAXB + 1 : stream_len;
        exp_re   = exp_over ? MAXB : stream_len;
        exp_done = exp_over ? 0 : 1;
        checks++;
        if (got_q.size() != exp_acc) begin
            errors++;
            $display("FAIL %s_bytes_sent: got %0d, required %0d", name, got_q.size(), exp_acc);
        end
        for (int i = 0; i < exp_acc && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte[%0d]: got %02h, required %02h", name, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ByteCount !== 16'(exp_acc)) begin
            errors++;
            $display("FAIL %s_bytecount: got %0d, required %0d", name, ByteCount, exp_acc);
        end
        checks++;
        if (re_count != exp_re) begin
            errors++;
            $display("FAIL %s_readenables: got %0d, required %0d", name, re_count, exp_re);
        end
        checks++;
        if (done_count != exp_done) begin
            errors++;
            $display("FAIL %s_donepulses: got %0d, required %0d", name, done_count, exp_done);
        end
        checks++;
        if (OverrunFlag !== exp_over || TimeoutFlag !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: overrun=%0b timeout=%0b, required %0b/0", name, OverrunFlag, TimeoutFlag, exp_over);
        end
        if (exp_done == 1) begin
            checks++;
            if (done_at != stream_len) begin
                errors++;
                $display("FAIL %s_done_timing: done after %0d bytes, required %0d", name, done_at, stream_len);
            end
        end
    endtask

    task automatic test_rearm_clears_and_arm_abort();
        cap_ready = 1'b0;
        ArmCmd    = 1'b1;
        AbortCmd  = 1'b1;
        tick();
        ArmCmd   = 1'b0;
        AbortCmd = 1'b0;
        checks++;
        if (Busy !== 1'b1 || TriggerEnable !== 1'b1 || OverrunFlag !== 1'b0 || ByteCount !== 16'd0) begin
            errors++;
            $display("FAIL arm_with_abort: Busy=%0b TE=%0b Ovr=%0b Cnt=%0d, required 1/1/0/0",
                     Busy, TriggerEnable, OverrunFlag, ByteCount);
        end
        AbortCmd = 1'b1;
        tick();
        AbortCmd = 1'b0;
        checks++;
        if (Busy !== 1'b0 || TriggerEnable !== 1'b0) begin
            errors++;
            $display("FAIL abort_armed: Busy=%0b TE=%0b, required 0/0", Busy, TriggerEnable);
        end
    endtask

    task automatic test_abort_present();
        int n;
        reset_dut();
        build_stream(1);
        tx_mode = 0;
        clear_counts();
        arm();
        repeat ($urandom_range(3, 10)) tick();
        cap_ready = 1'b1;
        n = 0;
        while (got_q.size() < 3 && n < 500) begin
            tick();
            n++;
        end
        tx_mode = 2;
        n = 0;
        while (!TxValid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (TxValid !== 1'b1 || TxData !== exp_q[3]) begin
            errors++;
            $display("FAIL abort_byte4_present: TxValid=%0b TxData=%02h, required 1/%02h", TxValid, TxData, exp_q[3]);
        end
        AbortCmd = 1'b1;
        tick();
        AbortCmd = 1'b0;
        checks++;
        if (Busy !== 1'b0 || TxValid !== 1'b0 || ReadEnable !== 1'b0 || ByteCount !== 16'd3) begin
            errors++;
            $display("FAIL abort_state: Busy=%0b TxValid=%0b RE=%0b Cnt=%0d, required 0/0/0/3",
                     Busy, TxValid, ReadEnable, ByteCount);
        end
        repeat (10) tick();
        checks++;
        if (done_count != 0 || re_count != 3) begin
            errors++;
            $display("FAIL abort_pulses: done=%0d re=%0d, required 0/3", done_count, re_count);
        end
        tx_mode = 0;
    endtask

    task automatic test_reset_midstream();
        int n;
        reset_dut();
        build_stream(2);
        tx_mode = 0;
        clear_counts();
        arm();
        repeat ($urandom_range(3, 10)) tick();
        cap_ready = 1'b1;
        n = 0;
        while (got_q.size() < 5 && n < 500) begin
            tick();
            n++;
        end
        Reset = 1'b1;
        tick();
        checks++;
        if ({TriggerEnable, ReadEnable, TxData, TxValid, Busy, DonePulse, TimeoutFlag, OverrunFlag, ByteCount} !== 31'd0) begin
            errors++;
            $display("FAIL reset_midstream: got %h, required 0",
                     {TriggerEnable, ReadEnable, TxData, TxValid, Busy, DonePulse, TimeoutFlag, OverrunFlag, ByteCount});
        end
        Reset     = 1'b0;
        cap_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_ready_at_expiry();
        run_stream(0, 1, "one_group");
        run_stream(1, 1, "throttled");
        run_stream(1, 2, "two_groups");
        run_stream(0, 3, "overrun");
        test_rearm_clears_and_arm_abort();
        test_abort_present();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
